// File: rtl/commit_unit.sv
// In-order retirement stage: picks up to two finished GL head entries per cycle,
// releases old physical registers, serialises stores and turns faults into a one-cycle trap.
module commit_unit #(
  parameter int unsigned PHY_REG_BITS = 6,
  parameter int unsigned GL_IDX_BITS  = 5,
  parameter int unsigned PC_BITS      = 40
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                head_valid_i,
  input  logic [1:0]                head_ex_i,
  input  logic [1:0]                head_is_store_i,
  input  logic [1:0]                head_is_csr_i,
  input  logic [1:0]                head_we_i,
  input  logic [2*PHY_REG_BITS-1:0] head_old_prd_i,
  input  logic [2*PC_BITS-1:0]      head_pc_i,
  input  logic [GL_IDX_BITS-1:0]    head_index_i,
  input  logic [63:0]               ex_cause_i,
  output logic [1:0]                read_head_o,
  output logic [1:0]                free_valid_o,
  output logic [2*PHY_REG_BITS-1:0] free_prd_o,
  output logic                      store_req_o,
  output logic [GL_IDX_BITS-1:0]    store_index_o,
  input  logic                      store_ack_i,
  output logic                      flush_commit_o,
  output logic                      trap_valid_o,
  output logic [PC_BITS-1:0]        trap_pc_o,
  output logic [63:0]               trap_cause_o,
  output logic [63:0]               instret_o
);

  localparam int unsigned CNT_BITS = 64;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    TRAP       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] retire_c;
  logic       latch_trap_c;
  logic       latch_store_c;
  logic       slot1_ok_c;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Slot 1 may pair with slot 0 only if neither needs serialising
  assign slot1_ok_c = head_valid_i[1] & ~head_ex_i[1] & ~head_is_store_i[1] &
                      ~head_is_csr_i[1] & ~head_is_csr_i[0];

  // Next-state and retire decision
  always_comb begin
    state_d       = state_q;
    retire_c      = 2'b00;
    latch_trap_c  = 1'b0;
    latch_store_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (head_valid_i[0]) begin
          if (head_ex_i[0]) begin
            latch_trap_c = 1'b1;
            state_d      = TRAP;
          end else if (head_is_store_i[0]) begin
            latch_store_c = 1'b1;
            state_d       = STORE_WAIT;
          end else begin
            retire_c = {slot1_ok_c, 1'b1};
          end
        end
      end
      STORE_WAIT: begin
        if (store_ack_i) begin
          retire_c = 2'b01;
          state_d  = RUN;
        end
      end
      TRAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign read_head_o    = retire_c;
  assign free_valid_o   = retire_c & head_we_i;
  assign free_prd_o     = head_old_prd_i;
  assign store_req_o    = (state_q == STORE_WAIT);
  assign flush_commit_o = (state_q == TRAP);
  assign trap_valid_o   = (state_q == TRAP);

  // Captured store index and fault information
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      store_index_o <= '0;
      trap_pc_o     <= '0;
      trap_cause_o  <= '0;
    end else begin
      if (latch_store_c) store_index_o <= head_index_i;
      if (latch_trap_c) begin
        trap_pc_o    <= head_pc_i[PC_BITS-1:0];
        trap_cause_o <= ex_cause_i;
      end
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) instret_o <= '0;
    else         instret_o <= instret_o + CNT_BITS'(retire_c[0]) + CNT_BITS'(retire_c[1]);
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage directly downstream of the graduation list. Each cycle it inspects the up-to-two oldest finished entries presented at the graduation list head and decides how many retire, driving the head-advance request back in the same cycle. It releases old physical destination registers to the rename free list, serialises stores and CSR instructions, and converts a faulting head entry into a one-cycle commit flush plus trap request. It also maintains the retired-instruction counter.

## Interface
- PHY_REG_BITS, 6, physical register index width
- GL_IDX_BITS, 5, graduation list index width
- PC_BITS, 40, PC width
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- head_valid_i  in  2  slot k holds a finished entry; slot 1 is only valid when slot 0 is valid
- head_ex_i  in  2  per-slot exception flag
- head_is_store_i  in  2  per-slot store/AMO flag
- head_is_csr_i  in  2  per-slot CSR/serialising flag
- head_we_i  in  2  per-slot "writes a register" flag
- head_old_prd_i  in  2×PHY_REG_BITS  per-slot old physical destination
- head_pc_i  in  2×PC_BITS  per-slot PC
- head_index_i  in  GL_IDX_BITS  GL index of slot 0
- ex_cause_i  in  64  cause from the GL exception register
- read_head_o  out  2  combinational retire mask to the GL: 00, 01 or 11
- free_valid_o  out  2  combinational free-list release strobes
- free_prd_o  out  2×PHY_REG_BITS  registers being released
- store_req_o  out  1  request to the LSQ to perform the head store
- store_index_o  out  GL_IDX_BITS  GL index of that store
- store_ack_i  in  1  LSQ has performed the store
- flush_commit_o  out  1  registered; flush the whole pipeline
- trap_valid_o  out  1  registered; trap request to the CSR file
- trap_pc_o  out  PC_BITS  registered faulting PC
- trap_cause_o  out  64  registered cause
- instret_o  out  64  retired-instruction count

## Operation
- States: RUN, STORE_WAIT, TRAP. Reset puts the block in RUN with every registered output at 0, including instret_o.
- RUN, slot 0 valid with head_ex_i[0]=1:
  - read_head_o=00.
  - Latch head_pc_i[0] and ex_cause_i.
  - Next state TRAP.
- RUN, slot 0 valid, store, no exception:
  - read_head_o=00.
  - Latch head_index_i into store_index_o.
  - Next state STORE_WAIT.
- RUN, slot 0 valid otherwise: slot 0 retires.
- Slot 1 also retires only if all of the following hold: slot 0 retires, slot 1 is valid, slot 1 is not ex, not store and not CSR, and slot 0 is not CSR. Otherwise read_head_o=01.
- STORE_WAIT:
  - store_req_o=1, held until store_ack_i.
  - The cycle store_ack_i=1: read_head_o=01, the store is released as a normal slot-0 retirement, and the next state is RUN.
  - store_ack_i while not in STORE_WAIT is ignored.
- TRAP: lasts exactly one cycle with flush_commit_o=1, trap_valid_o=1 and read_head_o=00, then returns to RUN. Inputs are ignored during TRAP.
- Release: free_valid_o[k] = retire[k] & head_we_i[k], and free_prd_o[k]=head_old_prd_i[k].
- instret_o += popcount(read_head_o) at each clock edge. It is 64-bit and wraps modulo 2^64.

## Timing
- read_head_o and free_* are same-cycle combinational functions of the head inputs and state. There is no register on the retire path.
- Non-store, non-faulting instructions retire at up to 2 per cycle with 0-cycle latency from head_valid_i.
- Store: minimum 2 cycles. Cycle 0 is RUN detect, cycle 1 is STORE_WAIT with req, and retirement happens in the ack cycle (≥ cycle 1).
- Trap: head valid with ex in cycle N, flush_commit_o/trap_valid_o high in cycle N+1 only. The GL flushes at that edge.
- When slot 0 is valid, slot 1 faulting or a store, slot 0 retires alone. Slot 1 becomes the new slot 0 next cycle and is handled there.
- Reset asserted mid-STORE_WAIT or TRAP aborts the operation immediately: store_req_o and flush outputs drop asynchronously, and the state returns to RUN.
- head_valid_i=00 gives read_head_o=00 and no state change.

## Test plan
- Two ALU ops at the head, both we=1, old_prd 5/9 -> read_head_o=11, free_valid_o=11, free_prd=5,9 that cycle, instret 0→2 at the edge.
- Slot 0 CSR, slot 1 ALU -> read_head_o=01; next cycle the ALU op alone gives 01; instret=2 total.
- Slot 0 store at index 7 -> cycle+1 store_req_o=1 with index 7; ack withheld 3 cycles gives read_head_o=00 throughout; ack -> 01, RUN.
- Slot 0 ALU, slot 1 faulting (pc 0x1000, cause 2) -> 01; next cycle 00 and enter TRAP; following cycle flush_commit_o=1, trap_pc_o=0x1000, trap_cause_o=2 for exactly one cycle.
- Preload instret to 2^64-1 via retirements, retire 2 -> wraps to 1.
- Assert rstn_i low during STORE_WAIT -> store_req_o=0 immediately; after release, state is RUN and instret_o=0.
